// File: rtl/beat_voice.sv
// beat_voice: percussive voice renderer fed by the step sequencer.
// A valid step strobe starts (or restarts) a square-wave tone or an LFSR
// noise burst whose amplitude decays linearly to silence. The amplitude
// is gated by the waveform phase into an 8-bit level, and that level also
// drives a 256-cycle PWM pin for the board's audio filter.
module beat_voice #(
  parameter int SAMPLE_DIV = 1250,  // clk cycles per sample tick
  parameter int ENV_DIV    = 40,    // sample ticks per envelope step
  parameter int DECAY_STEP = 1,     // amplitude decrement, codes 1-6
  parameter int HAT_DECAY  = 4      // amplitude decrement, code 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       step_strobe,
  input  logic [2:0] sample_code,
  output logic       busy,
  output logic [2:0] cur_voice,
  output logic [7:0] level,
  output logic       pwm_out
);

  // Counter widths follow the divider parameters; a divider of 1 still
  // gets a 1-bit counter so the compare below stays well formed.
  localparam int PRESC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int ENV_W   = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);
  localparam logic [ENV_W-1:0]   ENV_LAST   = ENV_W'(ENV_DIV - 1);
  localparam logic [7:0]         TONE_DEC   = 8'(DECAY_STEP);
  localparam logic [7:0]         HAT_DEC    = 8'(HAT_DECAY);
  localparam logic [15:0]        LFSR_SEED  = 16'hACE1;
  localparam logic [2:0]         HAT_CODE   = 3'd7;
  localparam logic [2:0]         NOISE_LO   = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    SOUND = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [2:0]         cur_voice_n;
  logic [7:0]         amp, amp_n;
  logic [7:0]         amp_dec;
  logic               phase, phase_n;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [ENV_W-1:0]   env_cnt, env_n;
  logic [5:0]         tone_cnt, tone_n;
  logic [15:0]        lfsr, lfsr_n;
  logic               lfsr_fb;
  logic               sample_tick;
  logic               trigger;
  logic [7:0]         pwm_cnt;

  // Half-period of each tone voice, in sample ticks.
  function automatic logic [5:0] half_period(input logic [2:0] code);
    case (code)
      3'd1:    half_period = 6'd40;
      3'd2:    half_period = 6'd24;
      3'd3:    half_period = 6'd16;
      3'd4:    half_period = 6'd12;
      default: half_period = 6'd8;
    endcase
  endfunction

  // A strobe only counts with playback enabled and a non-rest code; the
  // same condition starts a voice from IDLE and cuts/restarts one in SOUND.
  assign trigger = step_strobe && enable && (sample_code != 3'd0);

  // Fibonacci LFSR x^16+x^14+x^13+x^11, shifting towards bit 0.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Hi-hat decays faster than the other voices.
  assign amp_dec = (cur_voice == HAT_CODE) ? HAT_DEC : TONE_DEC;

  assign busy = (state == SOUND);

  // Next-state and datapath update: trigger, enable loss, then voicing.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the
    // if/case tree leaves one unassigned and no latch is inferred.
    state_n     = state;
    cur_voice_n = cur_voice;
    amp_n       = amp;
    phase_n     = phase;
    presc_n     = presc;
    env_n       = env_cnt;
    tone_n      = tone_cnt;
    lfsr_n      = lfsr;
    sample_tick = 1'b0;

    if (trigger) begin
      // Fresh start; a retrigger also wins over the envelope hitting 0.
      state_n     = SOUND;
      cur_voice_n = sample_code;
      amp_n       = 8'd255;
      phase_n     = 1'b1;
      presc_n     = '0;
      env_n       = '0;
      tone_n      = 6'd0;
    end else if (state == SOUND) begin
      if (!enable) begin
        state_n = IDLE;
      end else begin
        if (presc == PRESC_LAST) begin
          presc_n     = '0;
          sample_tick = 1'b1;
        end else begin
          presc_n = presc + 1'b1;
        end

        if (sample_tick) begin
          if (cur_voice >= NOISE_LO) begin
            lfsr_n  = {lfsr_fb, lfsr[15:1]};
            phase_n = lfsr_n[0];
          end else if (tone_cnt + 6'd1 == half_period(cur_voice)) begin
            phase_n = ~phase;
            tone_n  = 6'd0;
          end else begin
            tone_n = tone_cnt + 6'd1;
          end

          if (env_cnt == ENV_LAST) begin
            env_n = '0;
            amp_n = (amp > amp_dec) ? (amp - amp_dec) : 8'd0;
            if (amp_n == 8'd0) begin
              state_n = IDLE;
            end
          end else begin
            env_n = env_cnt + 1'b1;
          end
        end
      end
    end else begin
      // Idle: the voice code is cleared one cycle after leaving SOUND.
      cur_voice_n = 3'd0;
    end
  end

  // Voice state registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same clock edge, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_voice <= 3'd0;
      amp       <= 8'd0;
      phase     <= 1'b0;
      presc     <= '0;
      env_cnt   <= '0;
      tone_cnt  <= 6'd0;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= state_n;
      cur_voice <= cur_voice_n;
      amp       <= amp_n;
      phase     <= phase_n;
      presc     <= presc_n;
      env_cnt   <= env_n;
      tone_cnt  <= tone_n;
      lfsr      <= lfsr_n;
    end
  end

  // Output level: amplitude gated by the waveform phase, silent when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 8'd0;
    end else begin
      level <= (state == SOUND && phase) ? amp : 8'd0;
    end
  end

  // Free-running PWM frame counter and comparator; the 8-bit counter wraps
  // 255 to 0 by design, giving a 256-cycle frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= 8'd0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out <= (pwm_cnt < level);
    end
  end

endmodule
